// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the six-digit hex display controller
package seg7_pkg;

  localparam int DIGITS = 6;
  localparam logic [7:0] BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_COMMIT
  } scanStateT;

  // Active-low g..a patterns, entry 15 (F) first down to entry 0
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - update request handshake carrying value, blank and decimal-point masks
interface seg7_scan_ctrl_if;
  import seg7_pkg::*;

  logic                  iVALID;
  logic                  oREADY;
  logic [4*DIGITS-1:0]   iDATA;
  logic [DIGITS-1:0]     iBLANK;
  logic [DIGITS-1:0]     iDP;

  modport master (output iVALID, iDATA, iBLANK, iDP, input oREADY);
  modport slave  (input iVALID, iDATA, iBLANK, iDP, output oREADY);

endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex nibble to active-low 7-segment pattern
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - decodes six digits serially into a shadow register, then commits them at once
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter bit LZ_SUPPRESS = 1'b0
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  seg7_scan_ctrl_if.slave  upd,
  output logic [7:0]       oHEX0,
  output logic [7:0]       oHEX1,
  output logic [7:0]       oHEX2,
  output logic [7:0]       oHEX3,
  output logic [7:0]       oHEX4,
  output logic [7:0]       oHEX5
);

  scanStateT           state;
  logic [2:0]          idx;
  logic                readyReg;
  logic [4*DIGITS-1:0] dataReg;
  logic [DIGITS-1:0]   blankReg;
  logic [DIGITS-1:0]   dpReg;
  logic [7:0]          shadow [DIGITS];
  logic [7:0]          hexReg [DIGITS];

  logic [3:0] nibble;
  logic [6:0] seg;
  logic       blankBit;
  logic       dpBit;
  logic       lzBit;
  logic [7:0] zeroFrom;
  logic [7:0] digitCode;

  seg7_decode uDecode (
    .nibble (nibble),
    .seg    (seg)
  );

  // zeroFrom[n] is set when every nibble from n up to the top digit is zero
  always_comb begin
    zeroFrom = 8'hFF;
    for (int n = DIGITS - 1; n >= 0; n--) begin
      zeroFrom[n] = zeroFrom[n+1] && (dataReg[4*n +: 4] == 4'h0);
    end
  end

  always_comb begin
    nibble   = 4'h0;
    blankBit = 1'b0;
    dpBit    = 1'b0;
    case (idx)
      3'd0: begin nibble = dataReg[3:0];   blankBit = blankReg[0]; dpBit = dpReg[0]; end
      3'd1: begin nibble = dataReg[7:4];   blankBit = blankReg[1]; dpBit = dpReg[1]; end
      3'd2: begin nibble = dataReg[11:8];  blankBit = blankReg[2]; dpBit = dpReg[2]; end
      3'd3: begin nibble = dataReg[15:12]; blankBit = blankReg[3]; dpBit = dpReg[3]; end
      3'd4: begin nibble = dataReg[19:16]; blankBit = blankReg[4]; dpBit = dpReg[4]; end
      3'd5: begin nibble = dataReg[23:20]; blankBit = blankReg[5]; dpBit = dpReg[5]; end
      default: begin end
    endcase
    lzBit     = LZ_SUPPRESS && (idx != 3'd0) && zeroFrom[idx];
    digitCode = (blankBit || lzBit) ? BLANK : {~dpBit, seg};
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= ST_IDLE;
      idx      <= 3'd0;
      readyReg <= 1'b1;
      dataReg  <= '0;
      blankReg <= '0;
      dpReg    <= '0;
      for (int n = 0; n < DIGITS; n++) begin
        shadow[n] <= BLANK;
        hexReg[n] <= BLANK;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (upd.iVALID && readyReg) begin
            dataReg  <= upd.iDATA;
            blankReg <= upd.iBLANK;
            dpReg    <= upd.iDP;
            idx      <= 3'd0;
            readyReg <= 1'b0;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          shadow[idx] <= digitCode;
          if (idx == 3'(DIGITS - 1)) begin
            state <= ST_COMMIT;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        ST_COMMIT: begin
          for (int n = 0; n < DIGITS; n++) begin
            hexReg[n] <= shadow[n];
          end
          idx      <= 3'd0;
          readyReg <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          readyReg <= 1'b1;
        end
      endcase
    end
  end

  assign upd.oREADY = readyReg;
  assign oHEX0 = hexReg[0];
  assign oHEX1 = hexReg[1];
  assign oHEX2 = hexReg[2];
  assign oHEX3 = hexReg[3];
  assign oHEX4 = hexReg[4];
  assign oHEX5 = hexReg[5];

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed vector bench for the six-digit display controller
module tb_seg7_scan_ctrl;

  typedef struct {
    logic [23:0] data;
    logic [5:0]  blank;
    logic [5:0]  dp;
    bit          lz;
    logic [47:0] exp;   // {hex5, hex4, hex3, hex2, hex1, hex0}
  } vecT;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   tests = 0;
  int   failed = 0;

  logic [7:0] aHex [6];
  logic [7:0] bHex [6];
  logic [7:0] segExp [16];

  always #5 clk = ~clk;

  seg7_scan_ctrl_if busA ();
  seg7_scan_ctrl_if busB ();

  assign busB.iVALID = busA.iVALID;
  assign busB.iDATA  = busA.iDATA;
  assign busB.iBLANK = busA.iBLANK;
  assign busB.iDP    = busA.iDP;

  seg7_scan_ctrl #(.LZ_SUPPRESS(1'b0)) dutA (
    .iCLK(clk), .iRST_N(rstN), .upd(busA),
    .oHEX0(aHex[0]), .oHEX1(aHex[1]), .oHEX2(aHex[2]),
    .oHEX3(aHex[3]), .oHEX4(aHex[4]), .oHEX5(aHex[5])
  );

  seg7_scan_ctrl #(.LZ_SUPPRESS(1'b1)) dutB (
    .iCLK(clk), .iRST_N(rstN), .upd(busB),
    .oHEX0(bHex[0]), .oHEX1(bHex[1]), .oHEX2(bHex[2]),
    .oHEX3(bHex[3]), .oHEX4(bHex[4]), .oHEX5(bHex[5])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkHex(input string name, input bit lz, input logic [47:0] exp);
    for (int n = 0; n < 6; n++) begin
      check($sformatf("%s hex%0d", name, n), {24'h0, lz ? bHex[n] : aHex[n]}, {24'h0, exp[8*n +: 8]});
    end
  endtask

  function automatic logic [47:0] curHex(input bit lz);
    logic [47:0] r;
    for (int n = 0; n < 6; n++) r[8*n +: 8] = lz ? bHex[n] : aHex[n];
    return r;
  endfunction

  task automatic waitReady(input string name);
    int k = 0;
    @(negedge clk);
    while (!(busA.oREADY && busB.oREADY) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check({name, " ready timeout"}, 32'd0, 32'd1);
  endtask

  task automatic runUpdate(input string name, input vecT v);
    waitReady(name);
    busA.iVALID = 1'b1;
    busA.iDATA  = v.data;
    busA.iBLANK = v.blank;
    busA.iDP    = v.dp;
    @(posedge clk);
    @(negedge clk);
    busA.iVALID = 1'b0;
    check({name, " busy"}, {31'h0, v.lz ? busB.oREADY : busA.oREADY}, 32'd0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    checkHex(name, v.lz, v.exp);
    check({name, " ready"}, {31'h0, v.lz ? busB.oREADY : busA.oREADY}, 32'd1);
  endtask

  vecT vecs [$];

  initial begin
    logic [47:0] prev;
    vecT v;

    segExp = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
               8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    vecs.push_back('{24'h012345, 6'b000000, 6'b000000, 1'b0, {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}});
    vecs.push_back('{24'hABCDEF, 6'b000101, 6'b100010, 1'b0, {8'h08, 8'h83, 8'hC6, 8'hFF, 8'h06, 8'hFF}});
    vecs.push_back('{24'h000120, 6'b000000, 6'b000000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hC0}});
    vecs.push_back('{24'h000000, 6'b000000, 6'b000000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}});
    vecs.push_back('{24'h000100, 6'b000000, 6'b111111, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h79, 8'h40, 8'h40}});
    vecs.push_back('{24'h000120, 6'b000000, 6'b000000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hA4, 8'hC0}});
    vecs.push_back('{24'h100000, 6'b000001, 6'b000001, 1'b1, {8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF}});

    busA.iVALID = 1'b0;
    busA.iDATA  = '0;
    busA.iBLANK = '0;
    busA.iDP    = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkHex("reset", 1'b0, {6{8'hFF}});
    checkHex("reset lz", 1'b1, {6{8'hFF}});
    check("reset ready", {31'h0, busA.oREADY}, 32'd1);
    rstN = 1'b1;

    foreach (vecs[i]) runUpdate($sformatf("vec%0d", i), vecs[i]);

    // every nibble value through every digit position
    for (int k = 0; k < 16; k++) begin
      v.blank = '0;
      v.dp    = '0;
      v.lz    = 1'b0;
      for (int n = 0; n < 6; n++) begin
        v.data[4*n +: 4] = 4'((k + n) % 16);
        v.exp[8*n +: 8]  = segExp[(k + n) % 16];
      end
      runUpdate($sformatf("table%0d", k), v);
    end

    // busy: second request during DECODE is held off until E8
    waitReady("busy");
    prev = curHex(1'b0);
    busA.iVALID = 1'b1;
    busA.iDATA  = 24'h012345;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) busA.iDATA = 24'h543210;
      check($sformatf("atomic E%0d", c), {16'h0, curHex(1'b0)[15:0]}, {16'h0, prev[15:0]});
      check($sformatf("atomic hi E%0d", c), curHex(1'b0)[47:16], prev[47:16]);
    end
    @(posedge clk);
    @(negedge clk);
    checkHex("busy first", 1'b0, {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92});
    check("busy ready E7", {31'h0, busA.oREADY}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    busA.iVALID = 1'b0;
    check("busy accept E8", {31'h0, busA.oREADY}, 32'd0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    checkHex("busy second", 1'b0, {8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0});

    // reset mid-DECODE, then a clean update afterwards
    waitReady("midrst");
    busA.iVALID = 1'b1;
    busA.iDATA  = 24'h777777;
    busA.iDP    = 6'b111111;
    @(posedge clk);
    @(negedge clk);
    busA.iVALID = 1'b0;
    busA.iDP    = '0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    checkHex("midrst", 1'b0, {6{8'hFF}});
    check("midrst ready", {31'h0, busA.oREADY}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    v = '{24'h89ABCD, 6'b000000, 6'b000000, 1'b0, {8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1}};
    runUpdate("postrst", v);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
